// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - parametrised serial bit-sequence detector
// Mealy/Moore match outputs, runtime pattern/overlap config, saturating match counter.
module seq_detect_param #(
   parameter int SEQ_W = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             din_vld,
   input  logic             cfg_load,
   input  logic [SEQ_W-1:0] pattern,
   input  logic             overlap,
   input  logic             clr_cnt,
   output logic             dout_mealy,
   output logic             dout_moore,
   output logic [CNT_W-1:0] match_cnt,
   output logic             cnt_sat
);

   localparam int FILL_W = (SEQ_W > 2) ? $clog2(SEQ_W) : 1;
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SEQ_W - 1);

   logic [SEQ_W-1:0] pat_q, pat_d;
   logic             ovl_q, ovl_d;
   logic [SEQ_W-2:0] hist_q, hist_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic             moore_q, moore_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [SEQ_W-1:0] window;
   logic             full;
   logic             match;

   always_comb begin
      // window is the candidate sequence: stored history followed by the incoming bit
      window  = {hist_q, din};
      full    = (fill_q == FILL_MAX);
      match   = din_vld & ~cfg_load & ~rst & full & (window == pat_q);

      pat_d   = pat_q;
      ovl_d   = ovl_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      moore_d = match;
      cnt_d   = cnt_q;

      if (cfg_load) begin
         pat_d  = pattern;
         ovl_d  = overlap;
         hist_d = '0;
         fill_d = '0;
      end else if (din_vld) begin
         hist_d = window[SEQ_W-2:0];
         fill_d = full ? fill_q : fill_q + 1'b1;
         if (match && !ovl_q) begin
            hist_d = '0;
            fill_d = '0;
         end
      end

      if (clr_cnt)
         cnt_d = '0;
      else if (match && !(&cnt_q))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pat_q   <= '0;
         ovl_q   <= 1'b1;
         hist_q  <= '0;
         fill_q  <= '0;
         moore_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         pat_q   <= pat_d;
         ovl_q   <= ovl_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         moore_q <= moore_d;
         cnt_q   <= cnt_d;
      end
   end

   assign dout_mealy = match;
   assign dout_moore = moore_q;
   assign match_cnt  = cnt_q;
   assign cnt_sat    = &cnt_q;

endmodule
